// File: rtl/mem_lsu.sv
// ----------------------------------------------------------------------------
// mem_lsu -- load/store unit in front of a single-port synchronous word RAM.
//
// Handles word, halfword and byte loads and stores with little-endian lane
// mapping. Word stores write directly in the accept cycle. Sub-word stores do
// a read-modify-write: the RAM is read in the accept cycle, and the merged
// word is written one cycle later. Loads read the RAM, then extract and
// sign- or zero-extend the addressed lane. Misaligned accesses never touch
// the RAM and complete with resp_err.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; ready only while IDLE
//   req_we            1 = store, 0 = load
//   req_mod           00 word, 01 halfword, 1X byte
//   req_unsigned      zero-extend sub-word loads when 1
//   req_addr          byte address
//   req_wdata         store data, taken from the low lanes
//   resp_valid        one-cycle registered completion pulse
//   resp_err          misaligned access, qualified by resp_valid
//   resp_rdata        registered load result, 0 for stores and errors
//   ram_we/addr/din   RAM write enable, word address, write data
//   ram_dout          RAM read data, valid one cycle after its address
// ----------------------------------------------------------------------------
module mem_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_mod,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LD   = 2'd1,
    S_RMW  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          mod_q, mod_d;
  logic [1:0]          off_q, off_d;
  logic                uns_q, uns_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W-3:0]   waddr_q, waddr_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  logic                ready_c;
  logic                we_c;
  logic                misaligned;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_data;
  logic [31:0]         merged;

  // Halfwords need addr[0]=0; words need addr[1:0]=0; bytes are always aligned.
  assign misaligned = (req_mod == 2'b01 && req_addr[0]) ||
                      (req_mod == 2'b00 && req_addr[1:0] != 2'b00);

  // Lane extraction and store merge, both working on the word returned by the RAM.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (a latch).
    ld_byte = ram_dout[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    if (mod_q[1]) begin
      ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
    end else if (mod_q[0]) begin
      ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
    end else begin
      ld_data = ram_dout;
    end

    merged = ram_dout;
    if (mod_q[1]) begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    // NOTE: combinational logic uses blocking '='; the clocked block below
    // uses non-blocking '<=' only, so all registers update together.
    state_d      = state_q;
    mod_d        = mod_q;
    off_d        = off_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    waddr_d      = waddr_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    ready_c      = 1'b0;
    we_c         = 1'b0;
    ram_addr     = waddr_q;
    ram_din      = 32'h0;

    case (state_q)
      S_IDLE: begin
        ready_c  = 1'b1;
        ram_addr = req_addr[ADDR_W-1:2];
        if (req_valid) begin
          mod_d   = req_mod;
          off_d   = req_addr[1:0];
          uns_d   = req_unsigned;
          wdata_d = req_wdata[15:0];
          waddr_d = req_addr[ADDR_W-1:2];
          if (misaligned) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && req_mod == 2'b00) begin
            we_c         = 1'b1;
            ram_din      = req_wdata;
            resp_valid_d = 1'b1;
          end else if (req_we) begin
            state_d = S_RMW;
          end else begin
            state_d = S_LD;
          end
        end
      end
      S_LD: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
        state_d      = S_IDLE;
      end
      S_RMW: begin
        we_c         = 1'b1;
        ram_din      = merged;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must silence the handshake and the RAM strobe at once, not at the
  // next edge, so an access caught mid-flight never writes.
  assign req_ready = ready_c & rst_n;
  assign ram_we    = we_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mod_q        <= 2'b00;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= 16'h0;
      waddr_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      mod_q        <= mod_d;
      off_q        <= off_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      waddr_q      <= waddr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// ----------------------------------------------------------------------------
// tb_mem_lsu -- self-checking bench for mem_lsu with a behavioural word RAM.
// A table of directed accesses is applied one at a time; each access is
// observed for four cycles and its response cycle, data, error flag and RAM
// write pattern are compared with hand-computed values. Reset-during-RMW and
// back-to-back handshakes are covered by hand-written sequences.
// ----------------------------------------------------------------------------
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_mod;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:63];

  int n_checks;
  int n_fails;

  mem_lsu #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_mod     (req_mod),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  mod;
    logic        uns;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;   // cycle of resp_valid, counted from accept cycle 0
    logic [3:0]  exp_we;    // bit c set = ram_we high in cycle c
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 four cycles later.
  task automatic run_vec(input int idx, input vec_t v);
    logic [3:0]  we_mask;
    int          resp_cnt;
    int          resp_cyc;
    logic [31:0] got_rdata;
    logic        got_err;
    we_mask   = 4'b0000;
    resp_cnt  = 0;
    resp_cyc  = -1;
    got_rdata = 32'h0;
    got_err   = 1'b0;
    req_we       = v.we;
    req_mod      = v.mod;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check($sformatf("v%0d_ready_c0", idx), {31'h0, req_ready}, 32'h1);
        check($sformatf("v%0d_ram_addr_c0", idx), {26'h0, ram_addr}, {26'h0, v.addr[7:2]});
      end
      if (c == 1 && v.exp_cyc == 2) begin
        check($sformatf("v%0d_ready_c1", idx), {31'h0, req_ready}, 32'h0);
        check($sformatf("v%0d_ram_addr_c1", idx), {26'h0, ram_addr}, {26'h0, v.addr[7:2]});
      end
      if (ram_we) we_mask[c] = 1'b1;
      if (resp_valid) begin
        resp_cnt++;
        if (resp_cyc < 0) begin
          resp_cyc  = c;
          got_rdata = resp_rdata;
          got_err   = resp_err;
        end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
    check($sformatf("v%0d_resp_cycle", idx), resp_cyc, v.exp_cyc);
    check($sformatf("v%0d_resp_count", idx), resp_cnt, 32'd1);
    check($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
    check($sformatf("v%0d_err", idx), {31'h0, got_err}, {31'h0, v.exp_err});
    check($sformatf("v%0d_we_cycles", idx), {28'h0, we_mask}, {28'h0, v.exp_we});
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    //          we    mod    uns   addr   wdata         rdata         err   cyc we
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 8'h20, 32'h80FF7F01, 32'h00000000, 1'b0, 1, 4'b0001}; // sw
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 8'h20, 32'h0,        32'h00000001, 1'b0, 2, 4'b0000}; // lb
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 8'h23, 32'h0,        32'hFFFFFF80, 1'b0, 2, 4'b0000}; // lb
    vecs[3]  = '{1'b0, 2'b10, 1'b1, 8'h23, 32'h0,        32'h00000080, 1'b0, 2, 4'b0000}; // lbu
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 8'h22, 32'h0,        32'hFFFF80FF, 1'b0, 2, 4'b0000}; // lh
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 8'h20, 32'h0,        32'h00007F01, 1'b0, 2, 4'b0000}; // lhu
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 8'h21, 32'h000000AA, 32'h00000000, 1'b0, 2, 4'b0010}; // sb
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 8'h22, 32'h00001234, 32'h00000000, 1'b0, 2, 4'b0010}; // sh
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 8'h20, 32'h0,        32'h1234AA01, 1'b0, 2, 4'b0000}; // lw, uns ignored
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 8'h21, 32'h0,        32'h00000000, 1'b1, 1, 4'b0000}; // lw misaligned
    vecs[10] = '{1'b1, 2'b01, 1'b0, 8'h23, 32'h0000FFFF, 32'h00000000, 1'b1, 1, 4'b0000}; // sh misaligned
    vecs[11] = '{1'b0, 2'b00, 1'b0, 8'h20, 32'h0,        32'h1234AA01, 1'b0, 2, 4'b0000}; // lw unchanged
    vecs[12] = '{1'b0, 2'b11, 1'b0, 8'h22, 32'h0,        32'h00000034, 1'b0, 2, 4'b0000}; // lb, mod 11
    vecs[13] = '{1'b0, 2'b01, 1'b0, 8'h22, 32'h0,        32'h00001234, 1'b0, 2, 4'b0000}; // lh positive
    vecs[14] = '{1'b1, 2'b00, 1'b0, 8'h24, 32'h11223344, 32'h00000000, 1'b0, 1, 4'b0001}; // sw
    vecs[15] = '{1'b1, 2'b00, 1'b0, 8'h28, 32'hCAFEF00D, 32'h00000000, 1'b0, 1, 4'b0001}; // sw

    // Reset state.
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_mod      = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 8'h0;
    req_wdata    = 32'h0;
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_ram_we", {31'h0, ram_we}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset during the RMW cycle of sb 0x24: no write, no response.
    req_we    = 1'b1;
    req_mod   = 2'b10;
    req_addr  = 8'h24;
    req_wdata = 32'h000000EE;
    req_valid = 1'b1;
    @(negedge clk);
    check("rmwrst_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rmwrst_we_before", {31'h0, ram_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rmwrst_we_now", {31'h0, ram_we}, 32'h0);
    check("rmwrst_ready_now", {31'h0, req_ready}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rmwrst_resp_c%0d", c), {31'h0, resp_valid}, 32'h0);
      check($sformatf("rmwrst_we_c%0d", c), {31'h0, ram_we}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rmwrst_ready_after", {31'h0, req_ready}, 32'h1);
    check("rmwrst_no_resp", {31'h0, resp_valid}, 32'h0);
    check("rmwrst_mem_word", mem[9], 32'h11223344);
    @(posedge clk);
    #1;
    v = '{1'b0, 2'b00, 1'b0, 8'h24, 32'h0, 32'h11223344, 1'b0, 2, 4'b0000};
    run_vec(100, v);

    // Back-to-back: sb 0x28 then lw 0x28 with req_valid held high.
    req_we    = 1'b1;
    req_mod   = 2'b10;
    req_addr  = 8'h28;
    req_wdata = 32'h0000005A;
    req_valid = 1'b1;
    @(negedge clk);
    check("b2b_sb_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_we  = 1'b0;
    req_mod = 2'b00;
    @(negedge clk);
    check("b2b_c1_ready", {31'h0, req_ready}, 32'h0);
    check("b2b_c1_we", {31'h0, ram_we}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_sb_resp", {31'h0, resp_valid}, 32'h1);
    check("b2b_lw_accept", {31'h0, req_ready}, 32'h1);
    check("b2b_c2_we", {31'h0, ram_we}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_c3_resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_lw_resp", {31'h0, resp_valid}, 32'h1);
    check("b2b_lw_rdata", resp_rdata, 32'hCAFEF05A);
    check("b2b_lw_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    check("b2b_resp_once", {31'h0, resp_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
